// File: rtl/encrypt_sched.sv
// Packet-locked round-robin scheduler feeding one shared byte-encryption datapath.
// Each channel keeps its own rotating 24-bit key; returning results are tagged via a small FIFO.
module encrypt_sched #(
  parameter int          NUM_CH         = 4,
  parameter logic [23:0] KEY_INIT       = 24'hA5_3C_0F,
  parameter int          MAX_BEATS      = 64,
  parameter bit          RESYNC_ON_LAST = 1'b1,
  parameter int          TAG_DEPTH      = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   req_valid,
  input  logic [8*NUM_CH-1:0] req_data,
  input  logic [NUM_CH-1:0]   req_last,
  output logic [NUM_CH-1:0]   req_ready,
  input  logic                cfg_we,
  input  logic [2:0]          cfg_ch,
  input  logic [23:0]         cfg_key,
  output logic                ee_en,
  output logic [7:0]          ee_din,
  output logic [7:0]          ee_k1,
  output logic [7:0]          ee_k2,
  output logic [7:0]          ee_k3,
  input  logic                ee_v,
  output logic [2:0]          out_ch,
  output logic                busy,
  output logic                err_overrun,
  output logic                err_tag
);

  localparam int BW = $clog2(MAX_BEATS);
  localparam int AW = $clog2(TAG_DEPTH);
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BEATS - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(TAG_DEPTH);

  typedef enum logic [1:0] {IDLE, BURST, RELEASE} state_t;

  state_t        state, state_next;
  logic [2:0]    grant, rr_ptr, arb_idx;
  logic [3:0]    cand;
  logic          arb_found;
  logic [BW-1:0] beat_cnt;
  logic [7:0]    valid_ext, last_ext;
  logic [7:0]    data_ch [8];
  logic [23:0]   key_q [8];
  logic [23:0]   ee_key;
  logic          accept, overrun, pkt_end;

  logic [2:0]    tag_mem [TAG_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   tag_cnt;
  logic          fifo_full, fifo_empty, push, pop;

  // Widen the per-channel inputs to 8 entries so a 3-bit grant indexes them exactly.
  always_comb begin
    valid_ext = 8'(req_valid);
    last_ext  = 8'(req_last);
    for (int i = 0; i < 8; i++) data_ch[i] = 8'h00;
    for (int i = 0; i < NUM_CH; i++) data_ch[i] = req_data[8*i +: 8];
  end

  // First valid channel after rr_ptr, with wrap.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = {1'b0, rr_ptr} + 4'(i);
      if (cand >= 4'(NUM_CH)) cand = cand - 4'(NUM_CH);
      if (!arb_found && valid_ext[cand[2:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand[2:0];
      end
    end
  end

  assign fifo_full  = (tag_cnt == FULL_CNT);
  assign fifo_empty = (tag_cnt == '0);
  assign accept     = (state == BURST) && valid_ext[grant] && !fifo_full;
  assign overrun    = accept && !last_ext[grant] && (beat_cnt == LAST_BEAT);
  assign pkt_end    = accept && (last_ext[grant] || overrun);
  assign push       = accept;
  assign pop        = ee_v && !fifo_empty;

  // NOTE: every variable of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    req_ready  = '0;
    unique case (state)
      IDLE:    if (arb_found) state_next = BURST;
      BURST: begin
        req_ready = fifo_full ? '0 : (NUM_CH'(1) << grant);
        if (pkt_end) state_next = RELEASE;
      end
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy        = (state != IDLE);
  assign err_overrun = overrun;
  assign err_tag     = (ee_v && fifo_empty) || (push && fifo_full);
  assign out_ch      = fifo_empty ? 3'd0 : tag_mem[rd_ptr];
  assign {ee_k1, ee_k2, ee_k3} = ee_key;

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant    <= '0;
      rr_ptr   <= 3'(NUM_CH - 1);
      beat_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: if (arb_found) begin
          grant    <= arb_idx;
          beat_cnt <= '0;
        end
        BURST:   if (accept) beat_cnt <= beat_cnt + 1'b1;
        RELEASE: begin
          rr_ptr <= grant;
          grant  <= '0;
        end
        default: ;
      endcase
    end
  end

  // Issue stage: byte and pre-rotation key, held while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ee_en  <= 1'b0;
      ee_din <= '0;
      ee_key <= '0;
    end else begin
      ee_en <= accept;
      if (accept) begin
        ee_din <= data_ch[grant];
        ee_key <= key_q[grant];
      end
    end
  end

  // Configuration writes win over a same-cycle rotation of the same channel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) key_q[i] <= KEY_INIT;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_we && cfg_ch == 3'(i))
          key_q[i] <= cfg_key;
        else if (accept && grant == 3'(i))
          key_q[i] <= (pkt_end && RESYNC_ON_LAST) ? KEY_INIT
                                                  : {key_q[i][15:0], key_q[i][23:16]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      tag_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   tag_cnt <= tag_cnt + 1'b1;
        2'b01:   tag_cnt <= tag_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: tag storage is not reset; the pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= grant;
  end

endmodule

// File: tb/tb_encrypt_sched.sv
// Directed bench for encrypt_sched: a resyncing instance and a non-resyncing instance share stimulus.
// Per-channel byte sources are replayed cycle by cycle; issued bytes, keys and tags are logged and compared.
module tb_encrypt_sched;

  localparam int NUM_CH = 4;

  localparam logic [7:0] RR_DIN [12] = '{8'h01, 8'h02, 8'h11, 8'h12, 8'h31, 8'h32,
                                         8'h03, 8'h04, 8'h13, 8'h14, 8'h33, 8'h34};
  localparam int         RR_CH  [12] = '{0, 0, 1, 1, 3, 3, 0, 0, 1, 1, 3, 3};

  logic                clk = 1'b0;
  logic                rst;
  logic [NUM_CH-1:0]   req_valid, req_last, req_ready, nr_ready;
  logic [8*NUM_CH-1:0] req_data;
  logic                cfg_we;
  logic [2:0]          cfg_ch;
  logic [23:0]         cfg_key;
  logic                ee_v;
  logic                ee_en, busy, err_overrun, err_tag;
  logic [7:0]          ee_din, ee_k1, ee_k2, ee_k3;
  logic [2:0]          out_ch;
  logic                nr_en, nr_busy, nr_overrun, nr_tag;
  logic [7:0]          nr_din, nr_k1, nr_k2, nr_k3;
  logic [2:0]          nr_out_ch;

  always #5 clk = ~clk;

  encrypt_sched dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_key(cfg_key),
    .ee_en(ee_en), .ee_din(ee_din), .ee_k1(ee_k1), .ee_k2(ee_k2), .ee_k3(ee_k3),
    .ee_v(ee_v), .out_ch(out_ch), .busy(busy),
    .err_overrun(err_overrun), .err_tag(err_tag)
  );

  encrypt_sched #(.RESYNC_ON_LAST(1'b0)) dut_nr (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(nr_ready),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_key(cfg_key),
    .ee_en(nr_en), .ee_din(nr_din), .ee_k1(nr_k1), .ee_k2(nr_k2), .ee_k3(nr_k3),
    .ee_v(ee_v), .out_ch(nr_out_ch), .busy(nr_busy),
    .err_overrun(nr_overrun), .err_tag(nr_tag)
  );

  logic [8:0]        src [NUM_CH][128];
  int                src_len [NUM_CH];
  int                src_pos [NUM_CH];
  logic [NUM_CH-1:0] acc;
  bit                ee_auto, cfg_arm;
  logic              ee_man;
  int                cyc;

  logic [7:0]  iss_din [$];
  logic [23:0] iss_key [$];
  logic [23:0] nr_key  [$];
  int          iss_cyc [$];
  logic [2:0]  tag_log [$];
  int          ovr_cnt, ovr_at, tag_err_cnt;
  int          n_checks, n_fail;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    iss_din.delete(); iss_key.delete(); nr_key.delete();
    iss_cyc.delete(); tag_log.delete();
    ovr_cnt = 0; ovr_at = 0; tag_err_cnt = 0;
  endtask

  task automatic clear_src();
    for (int c = 0; c < NUM_CH; c++) begin
      src_len[c] = 0;
      src_pos[c] = 0;
    end
    acc = '0;
  endtask

  task automatic add_byte(input int ch, input logic [7:0] data, input logic last);
    src[ch][src_len[ch]] = {last, data};
    src_len[ch]++;
  endtask

  function automatic bit all_done();
    for (int c = 0; c < NUM_CH; c++)
      if (src_pos[c] + int'(acc[c]) < src_len[c]) return 1'b0;
    return 1'b1;
  endfunction

  // One clock: drive at the falling edge, sample everything 1 time unit before the rising edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    for (int c = 0; c < NUM_CH; c++) if (acc[c]) src_pos[c]++;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (src_pos[c] < src_len[c]) begin
        req_valid[c]         = 1'b1;
        req_data[8*c +: 8]   = src[c][src_pos[c]][7:0];
        req_last[c]          = src[c][src_pos[c]][8];
      end
    end
    ee_v   = ee_auto ? ee_en : ee_man;
    cfg_we = 1'b0;
    if (cfg_arm && req_ready[0] && req_valid[0]) begin
      cfg_we  = 1'b1;
      cfg_ch  = 3'd0;
      cfg_key = 24'h123456;
      cfg_arm = 1'b0;
    end
    #4;
    acc = req_valid & req_ready;
    if (ee_en) begin
      iss_din.push_back(ee_din);
      iss_key.push_back({ee_k1, ee_k2, ee_k3});
      iss_cyc.push_back(cyc);
    end
    if (nr_en)       nr_key.push_back({nr_k1, nr_k2, nr_k3});
    if (ee_v)        tag_log.push_back(out_ch);
    if (err_overrun) begin
      ovr_cnt++;
      ovr_at = src_pos[2] + 1;
    end
    if (err_tag)     tag_err_cnt++;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (n < 300 && !(all_done() && !busy && !ee_en)) begin
      step();
      n++;
    end
    check(tag, int'(n < 300), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    ee_man    = 1'b0;
    ee_v      = 1'b0;
    cfg_we    = 1'b0;
    clear_src();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    clear_logs();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, observed time %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0;
    rst = 1'b1;
    req_valid = '0; req_last = '0; req_data = '0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_key = '0;
    ee_v = 1'b0; ee_man = 1'b0; ee_auto = 1'b1; cfg_arm = 1'b0;
    clear_src();
    clear_logs();

    // Reset state
    #2 rst = 1'b0;
    #1;
    check("rst_ready",   int'(req_ready), 0);
    check("rst_ee_en",   int'(ee_en), 0);
    check("rst_ee_din",  int'(ee_din), 0);
    check("rst_ee_key",  int'({ee_k1, ee_k2, ee_k3}), 0);
    check("rst_out_ch",  int'(out_ch), 0);
    check("rst_busy",    int'(busy), 0);
    check("rst_err_ovr", int'(err_overrun), 0);
    check("rst_err_tag", int'(err_tag), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Single channel, three bytes
    add_byte(0, 8'h11, 1'b0);
    add_byte(0, 8'h22, 1'b0);
    add_byte(0, 8'h33, 1'b1);
    drain("t1_drain");
    check("t1_count", iss_din.size(), 3);
    check("t1_din0",  int'(iss_din[0]), 'h11);
    check("t1_din2",  int'(iss_din[2]), 'h33);
    check("t1_key0",  int'(iss_key[0]), 'hA53C0F);
    check("t1_key1",  int'(iss_key[1]), 'h3C0FA5);
    check("t1_key2",  int'(iss_key[2]), 'h0FA53C);
    check("t1_consec", iss_cyc[2] - iss_cyc[0], 2);
    check("t1_tags",  tag_log.size(), 3);
    for (int i = 0; i < 3; i++) check("t1_tag_ch", int'(tag_log[i]), 0);
    clear_logs();
    add_byte(0, 8'h44, 1'b1);
    drain("t1b_drain");
    check("t1_key_resync", int'(iss_key[0]), 'hA53C0F);

    // Round robin over ch0, ch1, ch3 with two 2-byte packets each
    do_reset();
    for (int p = 0; p < 2; p++) begin
      add_byte(0, 8'(8'h01 + 2*p), 1'b0); add_byte(0, 8'(8'h02 + 2*p), 1'b1);
      add_byte(1, 8'(8'h11 + 2*p), 1'b0); add_byte(1, 8'(8'h12 + 2*p), 1'b1);
      add_byte(3, 8'(8'h31 + 2*p), 1'b0); add_byte(3, 8'(8'h32 + 2*p), 1'b1);
    end
    drain("t2_drain");
    check("t2_count", iss_din.size(), 12);
    check("t2_tags",  tag_log.size(), 12);
    for (int i = 0; i < 12; i++) begin
      check("t2_din", int'(iss_din[i]), int'(RR_DIN[i]));
      check("t2_key", int'(iss_key[i]), (i % 2 == 0) ? 'hA53C0F : 'h3C0FA5);
      check("t2_tag", int'(tag_log[i]), RR_CH[i]);
    end
    for (int i = 1; i < 12; i++)
      check("t2_gap", iss_cyc[i] - iss_cyc[i-1], (i % 2 == 1) ? 1 : 3);

    // Key isolation: ch1 2 bytes, ch2 1 byte, ch1 again
    do_reset();
    add_byte(1, 8'h21, 1'b0); add_byte(1, 8'h22, 1'b1); add_byte(1, 8'h23, 1'b1);
    add_byte(2, 8'h41, 1'b1);
    drain("t3_drain");
    check("t3_order0", int'(iss_din[2]), 'h41);
    check("t3_order1", int'(iss_din[3]), 'h23);
    check("t3_nr_count", nr_key.size(), 4);
    check("t3_nr_key1", int'(nr_key[1]), 'h3C0FA5);
    check("t3_nr_ch2",  int'(nr_key[2]), 'hA53C0F);
    check("t3_nr_ch1b", int'(nr_key[3]), 'h0FA53C);
    check("t3_rs_ch1b", int'(iss_key[3]), 'hA53C0F);

    // Overrun: 64 bytes without last on ch2, then a short closing packet
    clear_logs();
    clear_src();
    for (int k = 0; k < 64; k++) add_byte(2, 8'(k), 1'b0);
    add_byte(2, 8'h80, 1'b0);
    add_byte(2, 8'h81, 1'b1);
    drain("t4_drain");
    check("t4_ovr_cnt", ovr_cnt, 1);
    check("t4_ovr_at",  ovr_at, 64);
    check("t4_count",   iss_din.size(), 66);
    check("t4_din63",   int'(iss_din[63]), 'h3F);
    check("t4_din64",   int'(iss_din[64]), 'h80);
    check("t4_key62",   int'(iss_key[62]), 'h0FA53C);
    check("t4_key64",   int'(iss_key[64]), 'hA53C0F);
    check("t4_key65",   int'(iss_key[65]), 'h3C0FA5);
    check("t4_gap",     iss_cyc[64] - iss_cyc[63], 3);

    // Configuration write in the same cycle as a ch0 accept
    clear_logs();
    clear_src();
    cfg_arm = 1'b1;
    add_byte(0, 8'h51, 1'b0);
    add_byte(0, 8'h52, 1'b1);
    drain("t5_drain");
    check("t5_old_key", int'(iss_key[0]), 'hA53C0F);
    check("t5_new_key", int'(iss_key[1]), 'h123456);

    // Backpressure from the tag FIFO, then err_tag on an extra ee_v
    clear_logs();
    clear_src();
    ee_auto = 1'b0;
    ee_man  = 1'b0;
    for (int k = 0; k < 6; k++) add_byte(0, 8'(8'h61 + k), (k == 5));
    repeat (10) step();
    check("t6_accepts4", src_pos[0], 4);
    check("t6_ready_lo", int'(req_ready), 0);
    check("t6_busy",     int'(busy), 1);
    ee_man = 1'b1;
    step();
    ee_man = 1'b0;
    repeat (4) step();
    check("t6_accepts5", src_pos[0], 5);
    check("t6_ready_lo2", int'(req_ready), 0);
    check("t6_no_tagerr", tag_err_cnt, 0);
    ee_man = 1'b1;
    repeat (6) step();
    ee_man = 1'b0;
    repeat (2) step();
    check("t6_tag_err",  tag_err_cnt, 1);
    check("t6_accepts6", src_pos[0], 6);
    check("t6_idle",     int'(busy), 0);

    // Reset in the middle of a burst
    clear_logs();
    clear_src();
    ee_auto = 1'b1;
    for (int k = 0; k < 10; k++) add_byte(0, 8'(8'h70 + k), (k == 9));
    repeat (4) step();
    check("t7_busy_pre",  int'(busy), 1);
    check("t7_ready_pre", int'(req_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t7_busy_rst",  int'(busy), 0);
    check("t7_ready_rst", int'(req_ready), 0);
    check("t7_en_rst",    int'(ee_en), 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      check("t7_en_hold", int'(ee_en), 0);
    end
    clear_src();
    clear_logs();
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) step();
    check("t7_no_issue", iss_din.size(), 0);
    check("t7_idle",     int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
